// File: rtl/load_use_dest_pipeline_if.sv
// ---------------------------------------------------------------------------
// load_use_dest_pipeline_if
// Bundles the ID-stage inputs and the forwarding-facing pipeline fields of
// load_use_dest_pipeline into one interface.
//
// Signals
//   id_valid, id_rs, id_rt, id_uses_rt, id_dst,
//   id_reg_write, id_mem_read, flush            : ID-stage side (master drives)
//   stall                                       : hold PC and IF/ID this cycle
//   ID_EX_Rs/Rt/Rd, ID_EX_MemRead               : EX-stage fields
//   EX_MEM_Rd, EX_MEM_RegWrite                  : MEM-stage fields
//   MEM_WB_Rd, MEM_WB_RegWrite                  : WB-stage fields
//   stall_cnt                                   : saturating load-use stall count
//
// Modports
//   master : the ID stage / environment that feeds instructions
//   slave  : the pipeline block itself
// ---------------------------------------------------------------------------
interface load_use_dest_pipeline_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] id_dst;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  flush;

   logic                  stall;
   logic [REG_ADDR_W-1:0] ID_EX_Rs;
   logic [REG_ADDR_W-1:0] ID_EX_Rt;
   logic [REG_ADDR_W-1:0] ID_EX_Rd;
   logic                  ID_EX_MemRead;
   logic [REG_ADDR_W-1:0] EX_MEM_Rd;
   logic                  EX_MEM_RegWrite;
   logic [REG_ADDR_W-1:0] MEM_WB_Rd;
   logic                  MEM_WB_RegWrite;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
      input  stall, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_MemRead,
             EX_MEM_Rd, EX_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
      output stall, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_MemRead,
             EX_MEM_Rd, EX_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite, stall_cnt
   );
endinterface

// File: rtl/load_use_dest_pipeline.sv
// ---------------------------------------------------------------------------
// load_use_dest_pipeline
// Carries destination register and control bits through the ID/EX, EX/MEM
// and MEM/WB pipeline registers for the EX-stage forwarding unit, detects
// load-use hazards that forwarding cannot cover, stalls IF/ID for one cycle
// and inserts a bubble into ID/EX.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : load_use_dest_pipeline_if.slave (ID inputs, stall, stage fields,
//            stall_cnt)
// ---------------------------------------------------------------------------
module load_use_dest_pipeline #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   load_use_dest_pipeline_if.slave  bus
);

   logic [REG_ADDR_W-1:0] r_idExRs;
   logic [REG_ADDR_W-1:0] r_idExRt;
   logic [REG_ADDR_W-1:0] r_idExRd;
   logic                  r_idExMemRead;
   logic                  r_idExRegWrite;
   logic [REG_ADDR_W-1:0] r_exMemRd;
   logic                  r_exMemRegWrite;
   logic [REG_ADDR_W-1:0] r_memWbRd;
   logic                  r_memWbRegWrite;
   logic [CNT_W-1:0]      r_stallCnt;

   logic                  w_hazard;
   logic                  w_stall;
   logic                  w_bubble;
   logic                  w_capRegWrite;
   logic                  w_capMemRead;
   logic                  w_cntSat;

   // A load sitting in EX cannot forward to the instruction in ID, because its
   // data only exists after MEM. If the ID instruction reads that register,
   // it must wait one cycle; afterwards MEM/WB forwarding covers it. The
   // $0 guard keeps a "load to $0" from ever stalling anything.
   always_comb begin
      w_hazard = r_idExMemRead && r_idExRegWrite && (r_idExRd != '0) && bus.id_valid &&
                 ((r_idExRd == bus.id_rs) || (bus.id_uses_rt && (r_idExRd == bus.id_rt)));
      w_stall  = w_hazard && !bus.flush;
      w_bubble = bus.flush || w_stall;
   end

   // Control bits are qualified at capture so a write to $0 never shows up as
   // RegWrite downstream and the forwarding unit can never match on $0.
   always_comb begin
      w_capRegWrite = bus.id_valid && bus.id_reg_write && (bus.id_dst != '0);
      w_capMemRead  = bus.id_valid && bus.id_mem_read;
      w_cntSat      = (r_stallCnt == {CNT_W{1'b1}});
   end

   // ID/EX register: a squash and a load-use stall both turn into a bubble
   // (all fields cleared); otherwise the ID instruction moves into EX. During
   // a stall the upstream stage holds its inputs, so the same instruction is
   // offered again on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idExRs       <= '0;
         r_idExRt       <= '0;
         r_idExRd       <= '0;
         r_idExMemRead  <= 1'b0;
         r_idExRegWrite <= 1'b0;
      end else if (w_bubble) begin
         r_idExRs       <= '0;
         r_idExRt       <= '0;
         r_idExRd       <= '0;
         r_idExMemRead  <= 1'b0;
         r_idExRegWrite <= 1'b0;
      end else begin
         r_idExRs       <= bus.id_rs;
         r_idExRt       <= bus.id_rt;
         r_idExRd       <= bus.id_dst;
         r_idExMemRead  <= w_capMemRead;
         r_idExRegWrite <= w_capRegWrite;
      end
   end

   // EX/MEM and MEM/WB never stall: whatever is in the stage ahead simply
   // moves down one slot every cycle, bubbles included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exMemRd       <= '0;
         r_exMemRegWrite <= 1'b0;
         r_memWbRd       <= '0;
         r_memWbRegWrite <= 1'b0;
      end else begin
         r_exMemRd       <= r_idExRd;
         r_exMemRegWrite <= r_idExRegWrite;
         r_memWbRd       <= r_exMemRd;
         r_memWbRegWrite <= r_exMemRegWrite;
      end
   end

   // Count cycles lost to load-use stalls. The counter sticks at all-ones
   // rather than wrapping, so a large reading is never mistaken for a small one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
      end else if (w_stall && !w_cntSat) begin
         r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.stall           = w_stall;
   assign bus.ID_EX_Rs        = r_idExRs;
   assign bus.ID_EX_Rt        = r_idExRt;
   assign bus.ID_EX_Rd        = r_idExRd;
   assign bus.ID_EX_MemRead   = r_idExMemRead;
   assign bus.EX_MEM_Rd       = r_exMemRd;
   assign bus.EX_MEM_RegWrite = r_exMemRegWrite;
   assign bus.MEM_WB_Rd       = r_memWbRd;
   assign bus.MEM_WB_RegWrite = r_memWbRegWrite;
   assign bus.stall_cnt       = r_stallCnt;

endmodule
